// File: rtl/sync_debouncer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_debouncer : synchronises a raw asynchronous level into clk and filters
//                  bounce; emits a clean level plus single-cycle edge pulses.
// Revision       : 1.0
// ---------------------------------------------------------------------------
module sync_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("sync_debouncer: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("sync_debouncer: DEBOUNCE_CYCLES must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [CNT_W-1:0]       cnt;
  state_t                 state;

  // Plain flop chain: nothing may sit between stages or metastability leaks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= STABLE_LO;
      cnt        <= '0;
      dout       <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      case (state)
        STABLE_LO: begin
          if (sync_out) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state      <= STABLE_HI;
              dout       <= 1'b1;
              rise_pulse <= 1'b1;
              cnt        <= '0;
              busy       <= 1'b0;
            end else begin
              state <= WAIT_HI;
              cnt   <= CNT_ONE;
              busy  <= 1'b1;
            end
          end
        end
        WAIT_HI: begin
          if (!sync_out) begin
            state <= STABLE_LO;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state      <= STABLE_HI;
            dout       <= 1'b1;
            rise_pulse <= 1'b1;
            cnt        <= '0;
            busy       <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!sync_out) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state      <= STABLE_LO;
              dout       <= 1'b0;
              fall_pulse <= 1'b1;
              cnt        <= '0;
              busy       <= 1'b0;
            end else begin
              state <= WAIT_LO;
              cnt   <= CNT_ONE;
              busy  <= 1'b1;
            end
          end
        end
        WAIT_LO: begin
          if (sync_out) begin
            state <= STABLE_HI;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state      <= STABLE_LO;
            dout       <= 1'b0;
            fall_pulse <= 1'b1;
            cnt        <= '0;
            busy       <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= STABLE_LO;
          cnt   <= '0;
          dout  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sync_debouncer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sync_debouncer : scoreboard bench for sync_debouncer (default instance
//                     plus a SYNC_STAGES=3 / DEBOUNCE_CYCLES=1 instance).
// Revision          : 1.0
// ---------------------------------------------------------------------------
module tb_sync_debouncer;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic din   = 1'b0;
  logic dout0, rise0, fall0, busy0;
  logic dout1, rise1, fall1, busy1;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  sync_debouncer dut0 (
    .clk(clk), .rst_n(rst_n), .din(din),
    .dout(dout0), .rise_pulse(rise0), .fall_pulse(fall0), .busy(busy0)
  );

  sync_debouncer #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din),
    .dout(dout1), .rise_pulse(rise1), .fall_pulse(fall1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   inst;
    int   cyc;
    logic d, r, f, b;
    bit   cb;
    int   tid;
  } exp_t;

  typedef struct {
    int   inst;
    int   off;
    logic flipped;
    logic pulse;
    logic bsy;
  } vec_t;

  exp_t  sb[$];
  vec_t  vecs[9];
  string names[6] = '{"rise", "fall", "glitch", "bounce", "fall2", "post_reset"};

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0b required=%0b", name, cyc, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  task automatic push(input int inst, input int c, input logic d, input logic r,
                      input logic f, input logic b, input bit cb, input int tid);
    exp_t e;
    e.inst = inst; e.cyc = c; e.d = d; e.r = r; e.f = f; e.b = b; e.cb = cb; e.tid = tid;
    sb.push_back(e);
  endtask

  // Drive a held transition now and queue the expected response of both DUTs.
  task automatic apply_transition(input bit dir, input int tid);
    int c0;
    c0  = cyc;
    din = dir;
    foreach (vecs[i]) begin
      push(vecs[i].inst, c0 + vecs[i].off,
           dir ? vecs[i].flipped : !vecs[i].flipped,
           dir ? vecs[i].pulse : 1'b0,
           dir ? 1'b0 : vecs[i].pulse,
           vecs[i].bsy, 1'b1, tid);
    end
    for (int off = 3; off <= 17; off++) push(0, c0 + off, !dir, 1'b0, 1'b0, 1'b1, 1'b1, tid);
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
    #1;
  endtask

  logic pd0 = 1'b0, pd1 = 1'b0;
  int   nrise0 = 0, nfall0 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pd0 = 1'b0;
      pd1 = 1'b0;
    end else begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc < cyc) begin
          check_int({names[sb[i].tid], "_expired"}, cyc, sb[i].cyc);
          sb.delete(i);
        end else if (sb[i].cyc == cyc) begin
          if (sb[i].inst == 0) begin
            check_bit({names[sb[i].tid], "_dout0"}, dout0, sb[i].d);
            check_bit({names[sb[i].tid], "_rise0"}, rise0, sb[i].r);
            check_bit({names[sb[i].tid], "_fall0"}, fall0, sb[i].f);
            if (sb[i].cb) check_bit({names[sb[i].tid], "_busy0"}, busy0, sb[i].b);
          end else begin
            check_bit({names[sb[i].tid], "_dout1"}, dout1, sb[i].d);
            check_bit({names[sb[i].tid], "_rise1"}, rise1, sb[i].r);
            check_bit({names[sb[i].tid], "_fall1"}, fall1, sb[i].f);
            if (sb[i].cb) check_bit({names[sb[i].tid], "_busy1"}, busy1, sb[i].b);
          end
          sb.delete(i);
        end
      end
      check_bit("dual_pulse0", rise0 & fall0, 1'b0);
      check_bit("rise_no_edge0", rise0 & !(dout0 & !pd0), 1'b0);
      check_bit("fall_no_edge0", fall0 & !(!dout0 & pd0), 1'b0);
      check_bit("rise_no_edge1", rise1 & !(dout1 & !pd1), 1'b0);
      check_bit("fall_no_edge1", fall1 & !(!dout1 & pd1), 1'b0);
      check_bit("busy1_never", busy1, 1'b0);
      pd0 = dout0;
      pd1 = dout1;
      if (rise0) nrise0++;
      if (fall0) nfall0++;
    end
  end

  initial begin
    int c0, nr, nf;
    // {inst, offset, dout flipped, pulse, busy}; offsets count from the drive cycle.
    vecs[0] = '{0,  1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{0,  2, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{0,  3, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{0, 17, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{0, 18, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{0, 19, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1,  3, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1,  4, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1,  5, 1'b1, 1'b0, 1'b0};

    #1 rst_n = 1'b0;
    #1;
    check_bit("reset_dout0", dout0, 1'b0);
    check_bit("reset_rise0", rise0, 1'b0);
    check_bit("reset_fall0", fall0, 1'b0);
    check_bit("reset_busy0", busy0, 1'b0);
    check_bit("reset_dout1", dout1, 1'b0);
    check_int("reset_cnt0", int'(dut0.cnt), 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;

    nr = nrise0; nf = nfall0; c0 = cyc;
    apply_transition(1'b1, 0);
    wait_to(c0 + 25);
    check_int("rise_count", nrise0 - nr, 1);
    check_int("rise_fall_count", nfall0 - nf, 0);

    nr = nrise0; nf = nfall0; c0 = cyc;
    apply_transition(1'b0, 1);
    wait_to(c0 + 25);
    check_int("fall_count", nfall0 - nf, 1);
    check_int("fall_rise_count", nrise0 - nr, 0);

    nr = nrise0; nf = nfall0; c0 = cyc;
    for (int off = 1; off <= 40; off++)
      push(0, c0 + off, 1'b0, 1'b0, 1'b0, (off >= 3 && off <= 12), 1'b1, 2);
    din = 1'b1;
    repeat (10) @(negedge clk);
    #1 din = 1'b0;
    wait_to(c0 + 41);
    check_int("glitch_cnt0", int'(dut0.cnt), 0);
    check_int("glitch_pulses", (nrise0 - nr) + (nfall0 - nf), 0);

    nr = nrise0; c0 = cyc;
    for (int off = 1; off <= 47; off++) push(0, c0 + off, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    push(0, c0 + 48, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3);
    push(0, c0 + 49, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3);
    for (int i = 0; i < 10; i++) begin
      din = (i % 2 == 0);
      repeat (3) @(negedge clk);
      #1;
    end
    din = 1'b1;
    wait_to(c0 + 60);
    check_int("bounce_rise_count", nrise0 - nr, 1);

    c0 = cyc;
    apply_transition(1'b0, 4);
    wait_to(c0 + 25);

    repeat (3) @(negedge clk);
    #1;
    din = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    check_bit("pre_reset_busy0", busy0, 1'b1);
    check_bit("pre_reset_dout1", dout1, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_bit("midreset_dout0", dout0, 1'b0);
    check_bit("midreset_busy0", busy0, 1'b0);
    check_bit("midreset_rise0", rise0, 1'b0);
    check_bit("midreset_fall0", fall0, 1'b0);
    check_bit("midreset_dout1", dout1, 1'b0);
    check_int("midreset_cnt0", int'(dut0.cnt), 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    nr = nrise0; c0 = cyc;
    apply_transition(1'b1, 5);
    wait_to(c0 + 25);
    check_int("post_reset_rise_count", nrise0 - nr, 1);

    check_int("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
